switch_sequencer: RTL

Scripted operator model that drives the four active-low switch lines of the main_graph controller in place of a human. It plays a fixed internal script of (switch pattern, hold time) steps on the same 1 ms tick base the controller uses. Its output feeds the debouncer input, so sequences are repeatable on the board and in simulation. Its position is the writer side of the switch interface that main_graph reads.

---
 rtl/switch_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/switch_sequencer.sv
// Scripted operator: plays (pattern, hold) steps onto the active-low switch lines on the 1 ms tick.
// Optional macro SWSEQ_LOOP_EN: after the last step the script restarts at step 0 until ABORT/RST.
module switch_sequencer #(
  parameter int STEPS     = 7,
  parameter int GAP_TICKS = 5,
  parameter int HOLD_W    = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       start_i,
  input  logic       abort_i,
  output logic [3:0] switch_out_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] step_o
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_GAP, S_FINISH} state_e;

  localparam logic [3:0]        LAST_STEP = 4'(STEPS - 1);
  localparam logic [HOLD_W-1:0] GAP_LD    = HOLD_W'(GAP_TICKS);
  localparam logic [HOLD_W-1:0] CNT_ONE   = HOLD_W'(1);
  localparam logic [3:0]        RELEASED  = 4'b1111;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [3:0]        step_q, step_d;
  logic [3:0]        sw_q, sw_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [3:0]        rom_pat;
  logic [15:0]       rom_hold;
  logic [HOLD_W-1:0] hold_ld;
  logic              adv;

  always_comb begin
    rom_pat  = RELEASED;
    rom_hold = 16'd1;
    case (step_q)
      4'd0: begin rom_pat = 4'b0111; rom_hold = 16'd50; end
      4'd1: begin rom_pat = 4'b1111; rom_hold = 16'd12; end
      4'd2: begin rom_pat = 4'b1101; rom_hold = 16'd50; end
      4'd3: begin rom_pat = 4'b1001; rom_hold = 16'd50; end
      4'd4: begin rom_pat = 4'b1110; rom_hold = 16'd50; end
      4'd5: begin rom_pat = 4'b0111; rom_hold = 16'd50; end
      4'd6: begin rom_pat = 4'b1110; rom_hold = 16'd50; end
      default: ;
    endcase
  end

  // A zero hold would otherwise wrap the down-counter; run it as one tick.
  assign hold_ld = (rom_hold == 16'd0) ? CNT_ONE : HOLD_W'(rom_hold);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    sw_d    = sw_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    adv     = 1'b0;
    case (state_q)
      S_IDLE: begin
        sw_d   = RELEASED;
        busy_d = 1'b0;
        if (start_i) begin
          state_d = S_LOAD;
          step_d  = 4'd0;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        cnt_d   = hold_ld;
        sw_d    = rom_pat;
        state_d = S_HOLD;
      end
      S_HOLD: if (tick_i) begin
        if (cnt_q == CNT_ONE) begin
          if (GAP_TICKS > 0) begin
            sw_d    = RELEASED;
            cnt_d   = GAP_LD;
            state_d = S_GAP;
          end else begin
            adv = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_GAP: if (tick_i) begin
        if (cnt_q == CNT_ONE) adv = 1'b1;
        else                  cnt_d = cnt_q - CNT_ONE;
      end
      S_FINISH: begin
`ifdef SWSEQ_LOOP_EN
        state_d = S_LOAD;
        step_d  = 4'd0;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    // In the gapless build the old pattern stays driven through LOAD, so steps abut.
    if (adv) begin
      if (step_q == LAST_STEP) begin
        state_d = S_FINISH;
        done_d  = 1'b1;
        sw_d    = RELEASED;
`ifdef SWSEQ_LOOP_EN
        busy_d  = 1'b1;
`else
        busy_d  = 1'b0;
`endif
      end else begin
        step_d  = step_q + 4'd1;
        state_d = S_LOAD;
      end
    end
    // STEP is deliberately kept so the aborted position can be inspected.
    if (abort_i) begin
      state_d = S_IDLE;
      step_d  = step_q;
      sw_d    = RELEASED;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      step_q  <= 4'd0;
      sw_q    <= RELEASED;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      sw_q    <= sw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign switch_out_o = sw_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign step_o       = step_q;
endmodule
